mmio_signature_monitor: RTL and testbench

MMIO_SIGNATURE_MONITOR -- requirements
Module: mmio_signature_monitor

---
 rtl/mmio_signature_monitor.sv | 185 ++++++++++++++++++
 tb/tb_mmio_signature_monitor.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_signature_monitor.sv
// Simulation-end monitor: decodes stop/trap/dump MMIO writes, runs the RUN/DRAIN/DONE
// termination sequence and queues signature dump records into a small FIFO.
module mmio_signature_monitor #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DATA_W       = 64,
  parameter int unsigned       NUM_CH       = 2,
  parameter int unsigned       FIFO_DEPTH   = 8,
  parameter int unsigned       DRAIN_CYCLES = 50,
  parameter int unsigned       IDLE_LIM     = 1000,
  parameter logic [ADDR_W-1:0] STOP_ADDR    = ADDR_W'(32'h6000_0000),
  parameter logic [ADDR_W-1:0] TRAP_ADDR    = ADDR_W'(32'h6000_0008),
  parameter logic [ADDR_W-1:0] DUMP_BASE    = ADDR_W'(32'h6000_0010)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mmio_req_i,
  input  logic              mmio_we_i,
  input  logic [ADDR_W-1:0] mmio_addr_i,
  input  logic [DATA_W-1:0] mmio_wdata_i,
  input  logic [31:0]       cfg_simlen_i,
  input  logic              cfg_trap_stop_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [2:0]        dump_ch_o,
  output logic [7:0]        dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_overflow_o,
  output logic [31:0]       cycle_cnt_o,
  output logic [15:0]       trap_cnt_o,
  output logic              done_o,
  output logic [2:0]        cause_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned ENT_W = 11 + DATA_W;
  localparam int unsigned DRN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [31:0]  IDLE_TGT = (IDLE_LIM == 0) ? 32'd0 : 32'(IDLE_LIM - 1);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] DEPTH_V = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [DRN_W-1:0] DRN_ONE = DRN_W'(1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       cause_q, cause_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic [31:0]      cycle_cnt_q, cycle_cnt_d;
  logic [31:0]      idle_cnt_q, idle_cnt_d;
  logic [15:0]      trap_cnt_q, trap_cnt_d;
  logic [7:0]       idx_q [NUM_CH];
  logic [7:0]       idx_d [NUM_CH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic [ENT_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] fifo_mem_d [FIFO_DEPTH];

  logic stop_ev, trap_ev, limit_hit, idle_hit;
  logic dump_hit, dump_take, fifo_full, fifo_nempty, pop;
  logic [2:0] dump_ch;
  logic [7:0] dump_idx;
  logic [ENT_W-1:0] head;

  assign stop_ev   = mmio_req_i && mmio_we_i && (mmio_addr_i == STOP_ADDR);
  assign trap_ev   = mmio_req_i && (mmio_addr_i == TRAP_ADDR);
  assign limit_hit = (cfg_simlen_i != 32'd0) && (cycle_cnt_q == cfg_simlen_i - 32'd1);
  assign idle_hit  = (IDLE_LIM != 0) && !mmio_req_i && (idle_cnt_q == IDLE_TGT);

  always_comb begin
    dump_hit = 1'b0;
    dump_ch  = '0;
    dump_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (mmio_req_i && mmio_we_i && (mmio_addr_i == DUMP_BASE + ADDR_W'(8 * k))) begin
        dump_hit = 1'b1;
        dump_ch  = 3'(k);
        dump_idx = idx_q[k];
      end
    end
  end

  // Cause priority inside RUN: stop > trap > limit > idle; limit skips the drain.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    drain_d = drain_q;
    case (state_q)
      ST_RUN: begin
        if (stop_ev) begin
          state_d = ST_DRAIN; cause_d = 3'd1; drain_d = DRN_W'(DRAIN_CYCLES);
        end else if (trap_ev && cfg_trap_stop_i) begin
          state_d = ST_DRAIN; cause_d = 3'd2; drain_d = DRN_W'(DRAIN_CYCLES);
        end else if (limit_hit) begin
          state_d = ST_DONE;  cause_d = 3'd3;
        end else if (idle_hit) begin
          state_d = ST_DRAIN; cause_d = 3'd4; drain_d = DRN_W'(DRAIN_CYCLES);
        end
      end
      ST_DRAIN: begin
        if (limit_hit || drain_q == '0) state_d = ST_DONE;
        else                            drain_d = drain_q - DRN_ONE;
      end
      default: ;
    endcase

    // The cycle that enters DONE is not counted, so the count freezes at the last active cycle.
    cycle_cnt_d = cycle_cnt_q;
    if (state_q != ST_DONE && state_d != ST_DONE && cycle_cnt_q != 32'hFFFF_FFFF)
      cycle_cnt_d = cycle_cnt_q + 32'd1;

    idle_cnt_d = idle_cnt_q;
    if (mmio_req_i)                         idle_cnt_d = '0;
    else if (state_q == ST_RUN && IDLE_LIM != 0) idle_cnt_d = idle_cnt_q + 32'd1;

    trap_cnt_d = trap_cnt_q;
    if (state_q == ST_RUN && trap_ev && trap_cnt_q != 16'hFFFF)
      trap_cnt_d = trap_cnt_q + 16'd1;
  end

  assign fifo_nempty = (wr_ptr_q != rd_ptr_q);
  assign fifo_full   = ((wr_ptr_q - rd_ptr_q) == DEPTH_V);
  assign pop         = fifo_nempty && dump_ready_i;
  assign dump_take   = dump_hit && (state_q == ST_RUN);

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    idx_d      = idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_d      = ovf_q;
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (dump_take) begin
      for (int k = 0; k < NUM_CH; k++)
        if (dump_ch == 3'(k)) idx_d[k] = idx_q[k] + 8'd1;
      // A dropped record still consumes its index so gaps reveal the loss.
      if (!fifo_full || pop) begin
        fifo_mem_d[wr_ptr_q[PTR_W-1:0]] = {dump_ch, dump_idx, mmio_wdata_i};
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      cause_q     <= '0;
      drain_q     <= '0;
      cycle_cnt_q <= '0;
      idle_cnt_q  <= '0;
      trap_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) idx_q[k] <= (k == 0) ? 8'd1 : 8'd0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      drain_q     <= drain_d;
      cycle_cnt_q <= cycle_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      trap_cnt_q  <= trap_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_q       <= ovf_d;
      idx_q       <= idx_d;
    end
  end

  always_ff @(posedge clk_i) begin
    fifo_mem_q <= fifo_mem_d;
  end

  assign head            = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
  assign dump_valid_o    = fifo_nempty;
  assign dump_ch_o       = fifo_nempty ? head[ENT_W-1 -: 3] : 3'd0;
  assign dump_idx_o      = fifo_nempty ? head[DATA_W +: 8] : 8'd0;
  assign dump_data_o     = fifo_nempty ? head[DATA_W-1:0] : '0;
  assign dump_overflow_o = ovf_q;
  assign cycle_cnt_o     = cycle_cnt_q;
  assign trap_cnt_o      = trap_cnt_q;
  assign done_o          = (state_q == ST_DONE);
  assign cause_o         = cause_q;

endmodule

// File: tb/tb_mmio_signature_monitor.sv
// Directed bench for mmio_signature_monitor: termination causes, drain timing,
// trap counting, dump FIFO ordering/overflow and mid-drain reset.
module tb_mmio_signature_monitor;

  localparam logic [31:0] STOP = 32'h6000_0000;
  localparam logic [31:0] TRAP = 32'h6000_0008;
  localparam logic [31:0] D0   = 32'h6000_0010;
  localparam logic [31:0] D1   = 32'h6000_0018;
  localparam logic [63:0] PAT  = 64'hA5A5_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic        req, we, ready, trap_stop;
  logic [31:0] addr, simlen;
  logic [63:0] wdata;

  logic        valid, ovf, done;
  logic [2:0]  ch, cause;
  logic [7:0]  idx;
  logic [63:0] data;
  logic [31:0] cyc;
  logic [15:0] trap;

  logic        i_valid, i_ovf, i_done;
  logic [2:0]  i_ch, i_cause;
  logic [7:0]  i_idx;
  logic [63:0] i_data;
  logic [31:0] i_cyc;
  logic [15:0] i_trap;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mmio_signature_monitor u_dut (
    .clk_i(clk), .rst_i(rst), .mmio_req_i(req), .mmio_we_i(we), .mmio_addr_i(addr),
    .mmio_wdata_i(wdata), .cfg_simlen_i(simlen), .cfg_trap_stop_i(trap_stop),
    .dump_valid_o(valid), .dump_ready_i(ready), .dump_ch_o(ch), .dump_idx_o(idx),
    .dump_data_o(data), .dump_overflow_o(ovf), .cycle_cnt_o(cyc), .trap_cnt_o(trap),
    .done_o(done), .cause_o(cause)
  );

  mmio_signature_monitor #(.IDLE_LIM(40)) u_dut_idle (
    .clk_i(clk), .rst_i(rst2), .mmio_req_i(req), .mmio_we_i(we), .mmio_addr_i(addr),
    .mmio_wdata_i(wdata), .cfg_simlen_i(simlen), .cfg_trap_stop_i(trap_stop),
    .dump_valid_o(i_valid), .dump_ready_i(ready), .dump_ch_o(i_ch), .dump_idx_o(i_idx),
    .dump_data_o(i_data), .dump_overflow_o(i_ovf), .cycle_cnt_o(i_cyc), .trap_cnt_o(i_trap),
    .done_o(i_done), .cause_o(i_cause)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic w, input logic [63:0] d);
    req = 1'b1; we = w; addr = a; wdata = d;
    step(1);
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    simlen = '0; trap_stop = 1'b0; ready = 1'b0;

    // reset state
    step(2);
    chk("rst_cyc", cyc, 0);
    chk("rst_done", done, 0);
    chk("rst_cause", cause, 0);
    chk("rst_valid", valid, 0);
    chk("rst_trap", trap, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_data", data, 0);
    rst = 1'b0;

    // stop at cycle 20, 50-cycle drain
    step(19);
    chk("pre_stop_cyc", cyc, 19);
    wr(STOP, 1'b1, 64'd0);
    chk("stop_cause", cause, 1);
    chk("stop_done", done, 0);
    chk("stop_cyc", cyc, 20);
    step(50);
    chk("drain70_done", done, 0);
    chk("drain70_cyc", cyc, 70);
    step(1);
    chk("done71", done, 1);
    chk("done71_cause", cause, 1);
    chk("done71_cyc", cyc, 70);
    step(5);
    chk("frozen_cyc", cyc, 70);
    chk("held_done", done, 1);

    // trap counting without and with termination
    do_reset();
    repeat (3) wr(TRAP, 1'b0, 64'd0);
    step(2);
    chk("trap3_cnt", trap, 3);
    chk("trap3_cause", cause, 0);
    chk("trap3_done", done, 0);
    trap_stop = 1'b1;
    wr(TRAP, 1'b0, 64'd0);
    chk("trapstop_cause", cause, 2);
    chk("trapstop_cnt", trap, 4);
    wr(TRAP, 1'b0, 64'd0);
    chk("trap_in_drain_cnt", trap, 4);
    trap_stop = 1'b0;

    // simulation length limit
    do_reset();
    simlen = 32'd100;
    step(99);
    chk("lim99_done", done, 0);
    step(1);
    chk("lim100_done", done, 1);
    chk("lim100_cause", cause, 3);
    chk("lim100_cyc", cyc, 99);

    // stop beats limit in the same cycle; limit later ends the drain early
    do_reset();
    simlen = 32'd10;
    step(9);
    wr(STOP, 1'b1, 64'd0);
    chk("prio_cause", cause, 1);
    chk("prio_done", done, 0);
    simlen = 32'd30;
    step(19);
    chk("drainlim29_done", done, 0);
    step(1);
    chk("drainlim30_done", done, 1);
    chk("drainlim30_cause", cause, 1);
    chk("drainlim30_cyc", cyc, 29);
    simlen = 32'd0;

    // idle timeout on the IDLE_LIM=40 instance
    rst2 = 1'b0;
    step(39);
    chk("idle39_cause", i_cause, 0);
    chk("idle39_cyc", i_cyc, 39);
    step(1);
    chk("idle40_cause", i_cause, 4);
    chk("idle40_done", i_done, 0);
    chk("idle40_cyc", i_cyc, 40);
    step(50);
    chk("idle90_done", i_done, 0);
    step(1);
    chk("idle91_done", i_done, 1);
    chk("idle91_cause", i_cause, 4);

    // ten ch0 dumps into an 8-deep FIFO with no consumer
    do_reset();
    ready = 1'b0;
    for (int i = 1; i <= 10; i++) wr(D0, 1'b1, PAT | 64'(i));
    step(3);
    chk("full_valid", valid, 1);
    chk("full_ovf", ovf, 1);
    chk("full_head_idx", idx, 1);
    chk("full_head_data", data, PAT | 64'd1);
    ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("pop_idx", idx, i);
      chk("pop_data", data, PAT | 64'(i));
      step(1);
    end
    chk("emptied_valid", valid, 0);
    wr(D0, 1'b1, PAT | 64'd11);
    chk("dump11_idx", idx, 11);
    chk("dump11_ch", ch, 0);
    chk("dump11_ovf", ovf, 1);
    step(1);
    chk("dump11_popped", valid, 0);

    // push into a full FIFO while it pops, then a dump after stop
    do_reset();
    ready = 1'b0;
    for (int i = 1; i <= 8; i++) wr(D0, 1'b1, PAT | 64'(i));
    chk("fill8_ovf", ovf, 0);
    ready = 1'b1;
    wr(D1, 1'b1, 64'hC1C1);
    chk("fullpop_ovf", ovf, 0);
    for (int i = 2; i <= 8; i++) begin
      chk("fp_ch", ch, 0);
      chk("fp_idx", idx, i);
      step(1);
    end
    chk("ch1_ch", ch, 1);
    chk("ch1_idx", idx, 0);
    chk("ch1_data", data, 64'hC1C1);
    step(1);
    chk("ch1_popped", valid, 0);
    wr(STOP, 1'b1, 64'd0);
    wr(D1, 1'b1, 64'hDEAD);
    step(1);
    chk("post_stop_dump_valid", valid, 0);
    chk("post_stop_cause", cause, 1);

    // reset in the middle of a drain with queued records
    do_reset();
    ready = 1'b0;
    for (int i = 1; i <= 3; i++) wr(D0, 1'b1, PAT | 64'(i));
    wr(STOP, 1'b1, 64'd0);
    chk("mid_cause", cause, 1);
    ready = 1'b1;
    step(1);
    chk("drain_pop_idx", idx, 2);
    ready = 1'b0;
    rst = 1'b1;
    step(1);
    chk("midrst_valid", valid, 0);
    chk("midrst_cause", cause, 0);
    chk("midrst_done", done, 0);
    chk("midrst_cyc", cyc, 0);
    rst = 1'b0;
    wr(D0, 1'b1, 64'h77);
    chk("midrst_ch0_idx", idx, 1);
    chk("midrst_ch0_data", data, 64'h77);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
